// File: rtl/ether_cmd_parser.sv
// ============================================================================
// Module      : ether_cmd_parser
// Description : Turns ether_rx_driver command frames into register-file writes.
//               Optional trailing XOR checksum: define ETHER_CMD_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ether_cmd_parser #(
    parameter logic [15:0] MAGIC          = 16'hCAFE,
    parameter int          ADDR_W         = 8,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              axiov,
    input  logic [31:0]       axiod,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [31:0]       wr_data_out,
    output logic              frame_done_out,
    output logic              err_out,
    output logic [1:0]        err_code_out,
    output logic              busy_out
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remain;
    logic [CNT_W-1:0]  idle_cnt;
    logic              idle_expired;
`ifdef ETHER_CMD_CHECKSUM_EN
    logic [31:0]       csum;
`endif

    // True on the idle cycle that completes a full TIMEOUT_CYCLES run.
    assign idle_expired = (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy_out       <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
            err_out        <= 1'b0;
            err_code_out   <= 2'b00;
            addr           <= '0;
            remain         <= '0;
            idle_cnt       <= '0;
`ifdef ETHER_CMD_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            err_out        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (axiov) begin
                        idle_cnt <= '0;
                        if (axiod[31:16] == MAGIC) begin
                            addr   <= ADDR_W'(axiod[15:8]);
                            remain <= axiod[7:0];
`ifdef ETHER_CMD_CHECKSUM_EN
                            csum     <= axiod;
                            busy_out <= 1'b1;
                            state    <= (axiod[7:0] == 8'd0) ? S_CHECK : S_PAYLOAD;
`else
                            if (axiod[7:0] == 8'd0) begin
                                frame_done_out <= 1'b1;
                            end else begin
                                busy_out <= 1'b1;
                                state    <= S_PAYLOAD;
                            end
`endif
                        end else begin
                            err_out      <= 1'b1;
                            err_code_out <= 2'b01;
                            busy_out     <= 1'b1;
                            state        <= S_DROP;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (axiov) begin
                        wr_en_out   <= 1'b1;
                        wr_addr_out <= addr;
                        wr_data_out <= axiod;
                        addr        <= addr + ADDR_W'(1);
                        remain      <= remain - 8'd1;
                        idle_cnt    <= '0;
`ifdef ETHER_CMD_CHECKSUM_EN
                        csum <= csum ^ axiod;
                        if (remain == 8'd1) begin
                            state <= S_CHECK;
                        end
`else
                        if (remain == 8'd1) begin
                            frame_done_out <= 1'b1;
                            busy_out       <= 1'b0;
                            state          <= S_IDLE;
                        end
`endif
                    end else if (idle_expired) begin
                        err_out      <= 1'b1;
                        err_code_out <= 2'b10;
                        busy_out     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end

`ifdef ETHER_CMD_CHECKSUM_EN
                S_CHECK: begin
                    if (axiov) begin
                        if (axiod == csum) begin
                            frame_done_out <= 1'b1;
                        end else begin
                            err_out      <= 1'b1;
                            err_code_out <= 2'b11;
                        end
                        busy_out <= 1'b0;
                        state    <= S_IDLE;
                    end else if (idle_expired) begin
                        err_out      <= 1'b1;
                        err_code_out <= 2'b10;
                        busy_out     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
`endif

                S_DROP: begin
                    // Words are discarded; only a quiet line ends the drop.
                    if (axiov) begin
                        idle_cnt <= '0;
                    end else if (idle_expired) begin
                        busy_out <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ether_cmd_parser.sv
// ============================================================================
// Module      : tb_ether_cmd_parser
// Description : Self-checking bench for ether_cmd_parser (frame-level model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ether_cmd_parser;

    localparam logic [15:0] MAGIC   = 16'hCAFE;
    localparam int          TIMEOUT = 1024;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        axiov = 1'b0;
    logic [31:0] axiod = '0;
    logic        wr_en_out;
    logic [7:0]  wr_addr_out;
    logic [31:0] wr_data_out;
    logic        frame_done_out;
    logic        err_out;
    logic [1:0]  err_code_out;
    logic        busy_out;

    ether_cmd_parser dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axiov          (axiov),
        .axiod          (axiod),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .frame_done_out (frame_done_out),
        .err_out        (err_out),
        .err_code_out   (err_code_out),
        .busy_out       (busy_out)
    );

    always #10 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Expected outputs for the edge that the next tick() waits on.
    bit          e_wr   = 1'b0;
    bit          e_done = 1'b0;
    bit          e_err  = 1'b0;
    bit          e_busy = 1'b0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic [1:0]  e_code = '0;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] data;
        bit          done;
        bit          err;
        logic [1:0]  code;
        bit          busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"},      32'(wr_en_out),      32'd0);
        chk({tag, " wr_addr"},    32'(wr_addr_out),    32'd0);
        chk({tag, " wr_data"},    wr_data_out,         32'd0);
        chk({tag, " frame_done"}, 32'(frame_done_out), 32'd0);
        chk({tag, " err"},        32'(err_out),        32'd0);
        chk({tag, " err_code"},   32'(err_code_out),   32'd0);
        chk({tag, " busy"},       32'(busy_out),       32'd0);
    endtask

    task automatic tick(input bit v, input logic [31:0] d);
        axiov = v;
        axiod = d;
        @(posedge clk);
        #1;
        chk("wr_en", 32'(wr_en_out), 32'(e_wr));
        if (e_wr) begin
            chk("wr_addr", 32'(wr_addr_out), 32'(e_addr));
            chk("wr_data", wr_data_out, e_data);
        end
        chk("frame_done", 32'(frame_done_out), 32'(e_done));
        chk("err",        32'(err_out),        32'(e_err));
        chk("err_code",   32'(err_code_out),   32'(e_code));
        chk("busy",       32'(busy_out),       32'(e_busy));
        e_wr   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        axiov  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom());
    endtask

    // Random quiet stretch inside a frame, always well below the timeout.
    task automatic gap(input int max_gap);
        if (max_gap > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, max_gap));
    endtask

    task automatic send_frame(input logic [7:0] start, input int n, input int max_gap);
        logic [31:0] hdr;
        logic [31:0] w;
        logic [31:0] cs;
        hdr = {MAGIC, start, 8'(n)};
        cs  = hdr;
`ifdef ETHER_CMD_CHECKSUM_EN
        e_busy = 1'b1;
`else
        if (n == 0) e_done = 1'b1;
        else        e_busy = 1'b1;
`endif
        tick(1'b1, hdr);
        for (int i = 0; i < n; i++) begin
            gap(max_gap);
            w      = $urandom();
            cs     = cs ^ w;
            e_wr   = 1'b1;
            e_addr = start + 8'(i);
            e_data = w;
`ifndef ETHER_CMD_CHECKSUM_EN
            if (i == n - 1) begin
                e_done = 1'b1;
                e_busy = 1'b0;
            end
`endif
            tick(1'b1, w);
        end
`ifdef ETHER_CMD_CHECKSUM_EN
        gap(max_gap);
        e_busy = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            cs     = cs ^ (32'h1 << $urandom_range(0, 31));
            e_err  = 1'b1;
            e_code = 2'b11;
        end else begin
            e_done = 1'b1;
        end
        tick(1'b1, cs);
`endif
    endtask

    task automatic send_bad(input int junk);
        logic [31:0] hdr;
        hdr = $urandom();
        if (hdr[31:16] == MAGIC) hdr[31] = ~hdr[31];
        e_err  = 1'b1;
        e_code = 2'b01;
        e_busy = 1'b1;
        tick(1'b1, hdr);
        for (int i = 0; i < junk; i++) begin
            gap(20);
            tick(1'b1, (i == 0) ? {MAGIC, 16'h0001} : $urandom());
        end
        idle(TIMEOUT - 1);
        e_busy = 1'b0;
        tick(1'b0, 32'd0);
    endtask

    task automatic send_timeout(input logic [7:0] start, input int n, input int k);
        logic [31:0] w;
        e_busy = 1'b1;
        tick(1'b1, {MAGIC, start, 8'(n)});
        for (int i = 0; i < k; i++) begin
            gap(5);
            w      = $urandom();
            e_wr   = 1'b1;
            e_addr = start + 8'(i);
            e_data = w;
            tick(1'b1, w);
        end
        idle(TIMEOUT - 1);
        e_err  = 1'b1;
        e_code = 2'b10;
        e_busy = 1'b0;
        tick(1'b0, 32'd0);
    endtask

`ifndef ETHER_CMD_CHECKSUM_EN
    function automatic vec_t mk(input bit v, input logic [31:0] d, input bit wr,
                                input logic [7:0] a, input logic [31:0] data,
                                input bit done, input bit busy);
        vec_t r;
        r.v = v; r.d = d; r.wr = wr; r.a = a; r.data = data;
        r.done = done; r.err = 1'b0; r.code = 2'b00; r.busy = busy;
        return r;
    endfunction
`endif

    initial begin
`ifndef ETHER_CMD_CHECKSUM_EN
        vec_t tbl[13];
`endif
        int kind;
        int n;

        // Reset state
        #15;
        chk_zero("reset");
        rst_n = 1'b1;

`ifndef ETHER_CMD_CHECKSUM_EN
        tbl[0]  = mk(1'b1, 32'hCAFE1003, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1);
        tbl[1]  = mk(1'b1, 32'h11111111, 1'b1, 8'h10, 32'h11111111, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 32'h22222222, 1'b1, 8'h11, 32'h22222222, 1'b0, 1'b1);
        tbl[3]  = mk(1'b1, 32'h33333333, 1'b1, 8'h12, 32'h33333333, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 32'hCAFEFE03, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 32'hCAFE0001, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 32'hA0000001, 1'b1, 8'hFE, 32'hA0000001, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 32'hA0000002, 1'b1, 8'hFF, 32'hA0000002, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 32'hA0000003, 1'b1, 8'h00, 32'hA0000003, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 32'hCAFE5500, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0);
        tbl[10] = mk(1'b1, 32'hCAFE0701, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1);
        tbl[11] = mk(1'b1, 32'h12345678, 1'b1, 8'h07, 32'h12345678, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 32'hCAFE0001, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            e_wr   = tbl[i].wr;
            e_addr = tbl[i].a;
            e_data = tbl[i].data;
            e_done = tbl[i].done;
            e_err  = tbl[i].err;
            e_code = tbl[i].code;
            e_busy = tbl[i].busy;
            tick(tbl[i].v, tbl[i].d);
        end
`else
        // Checksum match, then the same frame with a wrong checksum
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE0001);
        e_wr = 1'b1; e_addr = 8'h00; e_data = 32'h00000001;
        tick(1'b1, 32'h00000001);
        e_done = 1'b1; e_busy = 1'b0;
        tick(1'b1, 32'hCAFE0000);
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE0001);
        e_wr = 1'b1; e_addr = 8'h00; e_data = 32'h00000001;
        tick(1'b1, 32'h00000001);
        e_err = 1'b1; e_code = 2'b11; e_busy = 1'b0;
        tick(1'b1, 32'h00000000);
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE0500);
        e_done = 1'b1; e_busy = 1'b0;
        tick(1'b1, 32'hCAFE0500);
`endif

        // Reset in the middle of a frame
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE4003);
        e_wr = 1'b1; e_addr = 8'h40; e_data = 32'h0BAD0001;
        tick(1'b1, 32'h0BAD0001);
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        chk_zero("held reset");
        rst_n  = 1'b1;
        e_busy = 1'b0;
        e_code = 2'b00;
        idle(3);
        send_frame(8'h40, 3, 0);

        // Bad magic, drop, then recovery
        e_err = 1'b1; e_code = 2'b01; e_busy = 1'b1;
        tick(1'b1, 32'hBEEF0002);
        tick(1'b1, 32'h11111111);
        tick(1'b1, 32'h22222222);
        idle(TIMEOUT - 1);
        e_busy = 1'b0;
        tick(1'b0, 32'd0);
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE0001);
        e_wr = 1'b1; e_addr = 8'h00; e_data = 32'hAAAAAAAA;
`ifdef ETHER_CMD_CHECKSUM_EN
        tick(1'b1, 32'hAAAAAAAA);
        e_done = 1'b1; e_busy = 1'b0;
        tick(1'b1, 32'hCAFE0001 ^ 32'hAAAAAAAA);
`else
        e_done = 1'b1; e_busy = 1'b0;
        tick(1'b1, 32'hAAAAAAAA);
`endif

        // Payload timeout, then the next header is accepted
        e_busy = 1'b1;
        tick(1'b1, 32'hCAFE2002);
        e_wr = 1'b1; e_addr = 8'h20; e_data = 32'h5A5A5A5A;
        tick(1'b1, 32'h5A5A5A5A);
        idle(TIMEOUT - 1);
        e_err = 1'b1; e_code = 2'b10; e_busy = 1'b0;
        tick(1'b0, 32'd0);
        send_frame(8'h21, 2, 0);

        // Randomized frame mix
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 7) begin
                send_frame(8'($urandom()), int'($urandom_range(0, 8)), (kind == 0) ? 40 : 3);
            end else if (kind == 7) begin
                send_bad(int'($urandom_range(0, 3)));
            end else begin
                n = int'($urandom_range(1, 5));
`ifdef ETHER_CMD_CHECKSUM_EN
                send_timeout(8'($urandom()), n, int'($urandom_range(0, n)));
`else
                send_timeout(8'($urandom()), n, int'($urandom_range(0, n - 1)));
`endif
            end
            idle(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
